// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU datapath: sequences fetch/decode/execute/
// memory/write-back steps, drives datapath enables and mux selects, and emits ALUOp.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  state_t state_q, state_d;

  // Strobes that commit architectural state; gated by reset below.
  logic pc_write, pc_write_cond, ir_write, mem_write, reg_write, done, illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    PCSource      = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        ALUOp    = 2'b10;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 2'b10;
        case (opcode)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_R:            state_d = S_R_EXEC;
          OP_ADDI, OP_LUI: state_d = S_I_EXEC;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
        done      = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        RegDst    = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == OP_LUI) ? 2'b11 : 2'b10;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        PCSource      = 2'b01;
        done          = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSource = 2'b10;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign PCWrite     = pc_write      & ~rst;
  assign PCWriteCond = pc_write_cond & ~rst;
  assign IRWrite     = ir_write      & ~rst;
  assign MemWrite    = mem_write     & ~rst;
  assign RegWrite    = reg_write     & ~rst;
  assign instr_done  = done          & ~rst;
  assign illegal_op  = illegal       & ~rst;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction state-path model with
// randomized opcodes and memory wait states, plus directed reset and trace checks.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA, instr_done, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, rgw, rdst, srca;
    logic [1:0] pcsrc, srcb, aluop;
    logic       done, ill;
  } ctl_t;

  ctl_t got_ctl;
  assign got_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                    RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp, instr_done, illegal_op};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory model: a write lands at the edge closing a MemWrite && mem_ready cycle.
  int writes = 0;
  int exp_writes = 0;
  always @(negedge clk) if (MemWrite && mem_ready && !rst) writes++;

  // Reference model: each instruction is a list of states it visits; FETCH, MEM_READ
  // and MEM_WRITE wait for mem_ready before moving on.
  int         path[$];
  int         pidx = 0;
  bit         new_instr = 1'b1;
  logic [5:0] op_q[$];
  bit         mr_q[$];
  int         cyc = 0;
  int         done_q[$];

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0F};
  endfunction

  task automatic build_path(input logic [5:0] op);
    path.delete();
    case (op)
      6'h23:        path = '{0, 1, 2, 3, 4};
      6'h2B:        path = '{0, 1, 2, 5};
      6'h00:        path = '{0, 1, 6, 7};
      6'h08, 6'h0F: path = '{0, 1, 8, 9};
      6'h04:        path = '{0, 1, 10};
      6'h02:        path = '{0, 1, 11};
      default:      path = '{0, 1};
    endcase
  endtask

  function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic mr);
    ctl_t c = '0;
    case (st)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.aluop = 2'b10; c.irw = mr; c.pcw = mr; end
      1:  begin c.srcb = 2'b11; c.aluop = 2'b10; c.done = !is_legal(op); c.ill = !is_legal(op); end
      2:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rgw = 1; c.m2r = 1; c.done = 1; end
      5:  begin c.mwr = 1; c.iord = 1; c.done = mr; end
      6:  begin c.srca = 1; end
      7:  begin c.rgw = 1; c.rdst = 1; c.done = 1; end
      8:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = (op == 6'h0F) ? 2'b11 : 2'b10; end
      9:  begin c.rgw = 1; c.done = 1; end
      10: begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; c.done = 1; end
      11: begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0F};
    int unsigned r = $urandom_range(0, 8);
    if (r < 7) return ops[r];
    return 6'($urandom);
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step();
    int st;
    if (new_instr) begin
      opcode    = (op_q.size() != 0) ? op_q.pop_front() : rand_op();
      build_path(opcode);
      pidx      = 0;
      new_instr = 1'b0;
    end
    mem_ready = (mr_q.size() != 0) ? mr_q.pop_front() : 1'($urandom_range(0, 1));
    @(negedge clk);
    cyc++;
    st = path[pidx];
    check("state", 32'(state), 32'(st));
    check("ctl", 32'(got_ctl), 32'(exp_ctl(st, opcode, mem_ready)));
    if (instr_done) done_q.push_back(cyc);
    if (st == 5 && mem_ready) exp_writes++;
    if (!((st == 0 || st == 3 || st == 5) && !mem_ready)) begin
      if (pidx == path.size() - 1) new_instr = 1'b1;
      else pidx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int limit);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(new_instr && op_q.size() == 0) && n < limit);
    if (!(new_instr && op_q.size() == 0)) check("timeout", 32'd0, 32'd1);
  endtask

  int exp_done [5] = '{5, 9, 13, 16, 19};
  int w0;

  initial begin
    mem_ready = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctl", 32'(got_ctl), 32'(ctl_t'{mrd: 1'b1, srcb: 2'b01, aluop: 2'b10, default: '0}));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait trace: lw, sw, add, beq, j.
    cyc = 0;
    done_q.delete();
    op_q = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02};
    for (int i = 0; i < 19; i++) mr_q.push_back(1'b1);
    run_until_idle(40);
    check("done_count", 32'(done_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("done_cycle", (i < done_q.size()) ? 32'(done_q[i]) : 32'hFFFF, 32'(exp_done[i]));

    // FETCH stalled three cycles, then addi.
    op_q = '{6'h08};
    mr_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    run_until_idle(20);

    // lui, undefined opcode, beq with random wait states.
    op_q = '{6'h0F, 6'h3F, 6'h04};
    run_until_idle(60);

    // Randomized instruction stream.
    for (int i = 0; i < 400; i++) step();
    run_until_idle(200);
    check("writes", 32'(writes), 32'(exp_writes));

    // Reset during a stalled MEM_WRITE must abort the store.
    op_q = '{6'h2B};
    mr_q = '{1'b1, 1'b1, 1'b1};
    step(); step(); step();
    mem_ready = 1'b0;
    @(negedge clk);
    check("mw_state", 32'(state), 32'd5);
    check("mw_pending", 32'(MemWrite), 32'd1);
    w0 = writes;
    #2 rst = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("abort_irwrite", 32'(IRWrite), 32'd0);
    @(negedge clk);
    check("abort_writes", 32'(writes), 32'(w0));
    check("abort_hold", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    path.delete();
    new_instr = 1'b1;
    op_q = '{6'h23};
    run_until_idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
